// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op and state encodings plus iteration count.
package mdu_pkg;

  localparam int WIDTH   = 32;
  localparam int MD_ITER = WIDTH;
  localparam int CNT_W   = $clog2(MD_ITER);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the datapath and the MDU.
// The datapath is master; the MDU is slave.
interface mdu_if;
  import mdu_pkg::*;

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWe;
  logic             LoWe;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, HiWe, LoWe,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, HiWe, LoWe,
    output Busy, Done, HI, LO
  );

endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the top owns all state.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0]   sum;
  logic [W:0]   top;
  logic [W:0]   diff;
  logic [W-1:0] rem;

  always_comb begin
    sum      = '0;
    top      = '0;
    diff     = '0;
    rem      = '0;
    q_bit    = 1'b0;
    acc_next = acc;
    if (is_div) begin
      // Shifted partial remainder needs W+1 bits.
      top      = acc[2*W-1:W-1];
      diff     = top - {1'b0, opnd};
      q_bit    = ~diff[W];
      rem      = q_bit ? diff[W-1:0] : top[W-1:0];
      acc_next = {rem, acc[W-2:0], 1'b0};
    end else begin
      sum = {1'b0, acc[2*W-1:W]};
      if (acc[0]) begin
        sum = sum + {1'b0, opnd};
      end
      acc_next = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Sign handling wraps an unsigned 32-step core.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  mdu_if.slave bus
);

  localparam int W = WIDTH;

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   araw_q, araw_d;
  logic           div_q, div_d;
  logic           neg_q, neg_d;
  logic           rsgn_q, rsgn_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic [2*W-1:0] step_acc;
  logic           step_q;

  logic           op_div;
  logic           op_sgn;
  logic           sa;
  logic           sb;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  mdu_step #(.W(W)) u_step (
    .is_div   (div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  assign op_div = bus.Op[1];
  assign op_sgn = ~bus.Op[0];
  assign sa     = op_sgn & bus.A[W-1];
  assign sb     = op_sgn & bus.B[W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rsgn_d  = rsgn_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem     = rsgn_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = {{W{1'b0}}, sa ? -bus.A : bus.A};
          opnd_d  = sb ? -bus.B : bus.B;
          araw_d  = bus.A;
          div_d   = op_div;
          neg_d   = sa ^ sb;
          rsgn_d  = sa;
          dz_d    = op_div & (bus.B == '0);
        end else begin
          if (bus.HiWe) hi_d = bus.A;
          if (bus.LoWe) lo_d = bus.A;
        end
      end
      S_RUN: begin
        acc_d = div_q ? {step_acc[2*W-1:1], step_q}
                      : step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MD_ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rsgn_q  <= rsgn_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus
// hand-written busy/reset/MTHI sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic Clk;
  logic Rst_n;
  int   n_vec;
  int   n_bad;

  mdu_if bus ();

  mult_div_unit dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // inj: 0 none, 1 Start pulse at cycle 5,
  // 2 HiWe at cycle 3, 3 HiWe asserted with Start.
  task automatic run_op(input logic [1:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int          inj,
                        input logic [31:0] prev_hi);
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    bus.HiWe  = (inj == 3);
    bus.LoWe  = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      bus.HiWe  = 1'b0;
      if (inj == 3 && c == 1)
        check("hiwe_with_start", bus.HI, prev_hi);
      if (inj == 1 && c == 5) begin
        bus.Start = 1'b1;
        bus.Op    = MD_MULTU;
        bus.A     = 32'd2;
        bus.B     = 32'd3;
      end
      if (inj == 2 && c == 3) begin
        bus.HiWe = 1'b1;
        bus.A    = 32'hDEADBEEF;
      end
      if (inj == 2 && c == 10)
        check("hiwe_busy", bus.HI, prev_hi);
      check($sformatf("busy_c%0d", c),
            bus.Busy, (c <= 33));
      check($sformatf("done_c%0d", c),
            bus.Done, (c == 34));
    end
    check("hi", bus.HI, ehi);
    check("lo", bus.LO, elo);
    if (inj == 1) begin
      @(negedge Clk);
      check("no_2nd_done", bus.Done, 1'b0);
      check("no_2nd_busy", bus.Busy, 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    vt[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001};
    vt[1] = '{MD_MULT, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2] = '{MD_DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{MD_DIVU, 32'd100, 32'd0,
              32'h00000064, 32'hFFFFFFFF};
    vt[4] = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000};
    vt[5] = '{MD_DIV, 32'hFFFFFFF9, 32'd0,
              32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[6] = '{MD_DIV, 32'd7, 32'hFFFFFFFE,
              32'h00000001, 32'hFFFFFFFD};
    vt[7] = '{MD_MULT, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h00000000};
    vt[8] = '{MD_MULTU, 32'h12345678, 32'h10,
              32'h00000001, 32'h23456780};
    vt[9] = '{MD_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14};

    Rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.HiWe  = 1'b0;
    bus.LoWe  = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Back-to-back: each op starts in the previous Done cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b,
             vt[i].hi, vt[i].lo, 0, 32'h0);
    end

    @(negedge Clk);
    bus.HiWe = 1'b1;
    bus.A    = 32'h12345678;
    @(negedge Clk);
    bus.HiWe = 1'b0;
    check("mthi", bus.HI, 32'h12345678);
    check("mthi_lo_kept", bus.LO, 32'd14);
    bus.HiWe = 1'b1;
    bus.LoWe = 1'b1;
    bus.A    = 32'hAAAA5555;
    @(negedge Clk);
    bus.HiWe = 1'b0;
    bus.LoWe = 1'b0;
    check("mthi_both", bus.HI, 32'hAAAA5555);
    check("mtlo_both", bus.LO, 32'hAAAA5555);

    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE,
           32'd1, 32'hFFFFFFFD, 2, 32'hAAAA5555);
    run_op(MD_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 1, 32'h0);
    run_op(MD_MULTU, 32'h00010000, 32'h00030000,
           32'd3, 32'd0, 3, 32'd2);

    // Abort a MULTU partway with reset.
    @(negedge Clk);
    bus.Op    = MD_MULTU;
    bus.A     = 32'd5;
    bus.B     = 32'd6;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("pre_rst_busy", bus.Busy, 1'b1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.Busy, 1'b0);
    check("mid_rst_hi", bus.HI, 32'h0);
    check("mid_rst_lo", bus.LO, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    begin
      logic saw;
      saw = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge Clk);
        if (bus.Done) saw = 1'b1;
      end
      check("no_done_after_rst", saw, 1'b0);
    end
    run_op(MD_MULTU, 32'd5, 32'd6,
           32'd0, 32'd30, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
